// File: rtl/peak_sched.sv
// peak_sched: forwards whole FFT frames into peak_detect only when it is idle and the decimation slot is due.
// Define PEAK_SCHED_STATS_EN to add saturating drop/error/timeout counters.
module peak_sched #(
  parameter int WIDTH   = 16,
  parameter int NBINS   = 4096,
  parameter int NPEAKS  = 4,
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fft_valid,
  input  logic             fft_sop,
  input  logic             fft_eop,
  input  logic [WIDTH-1:0] fft_mag,
  input  logic [15:0]      fft_phase,
  output logic             pd_sink_valid,
  output logic             pd_sink_sop,
  output logic             pd_sink_eop,
  output logic [WIDTH-1:0] pd_sink_mag,
  output logic [15:0]      pd_sink_phase,
  input  logic             pd_valid,
  input  logic             pd_eop,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_drop,
  output logic             frame_err,
  output logic             timeout
`ifdef PEAK_SCHED_STATS_EN
  ,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      tmo_cnt
`endif
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(NBINS - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  // A detector configured for zero records never signals completion.
  localparam bit DETECTOR_REPORTS = (NPEAKS > 0);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_SKIP, S_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next, dcnt_inc;
  logic [BW-1:0] bcnt_reg, bcnt_next, bcnt_inc;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          fwd_valid, fwd_sop, fwd_eop;
  logic          done_next, drop_next, err_next, tmo_next;
  logic          sop_beat, eop_beat, pd_complete;

  always_comb begin
    sop_beat    = fft_valid && fft_sop;
    eop_beat    = fft_valid && fft_eop;
    pd_complete = pd_valid && pd_eop && DETECTOR_REPORTS;
    dcnt_inc    = (dcnt_reg == DCNT_LAST) ? '0 : dcnt_reg + 1'b1;
    bcnt_inc    = (bcnt_reg == '1) ? bcnt_reg : bcnt_reg + 1'b1;

    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    bcnt_next  = bcnt_reg;
    tcnt_next  = '0;
    fwd_valid  = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = 1'b0;
    done_next  = 1'b0;
    drop_next  = 1'b0;
    err_next   = 1'b0;
    tmo_next   = 1'b0;

    case (state_reg)
      S_IDLE, S_SKIP: begin
        // SKIP resynchronises on any sop exactly like IDLE.
        if (sop_beat) begin
          dcnt_next = dcnt_inc;
          if (dcnt_reg == '0) begin
            fwd_valid  = 1'b1;
            fwd_sop    = 1'b1;
            fwd_eop    = fft_eop;
            bcnt_next  = '0;
            state_next = fft_eop ? S_WAIT : S_PASS;
          end else begin
            state_next = fft_eop ? S_IDLE : S_SKIP;
          end
        end else if (state_reg == S_SKIP && eop_beat) begin
          state_next = S_IDLE;
        end
      end
      S_PASS: begin
        if (fft_valid) begin
          fwd_valid = 1'b1;
          if (fft_sop && !fft_eop) begin
            // Truncate the detector's frame with an eop so it resets cleanly.
            fwd_eop    = 1'b1;
            err_next   = 1'b1;
            drop_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            fwd_sop   = fft_sop;
            fwd_eop   = fft_eop;
            bcnt_next = bcnt_inc;
            if (fft_eop) begin
              state_next = S_WAIT;
              err_next   = (bcnt_inc != BCNT_LAST);
            end
          end
        end
      end
      S_WAIT: begin
        tcnt_next = tcnt_reg + 1'b1;
        drop_next = sop_beat;
        if (pd_complete) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (tcnt_reg == TCNT_LAST) begin
          tmo_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      dcnt_reg      <= '0;
      bcnt_reg      <= '0;
      tcnt_reg      <= '0;
      pd_sink_valid <= 1'b0;
      pd_sink_sop   <= 1'b0;
      pd_sink_eop   <= 1'b0;
      pd_sink_mag   <= '0;
      pd_sink_phase <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_drop    <= 1'b0;
      frame_err     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dcnt_reg      <= dcnt_next;
      bcnt_reg      <= bcnt_next;
      tcnt_reg      <= tcnt_next;
      pd_sink_valid <= fwd_valid;
      pd_sink_sop   <= fwd_sop;
      pd_sink_eop   <= fwd_eop;
      pd_sink_mag   <= fft_mag;
      pd_sink_phase <= fft_phase;
      busy          <= (state_next == S_PASS) || (state_next == S_WAIT);
      frame_done    <= done_next;
      frame_drop    <= drop_next;
      frame_err     <= err_next;
      timeout       <= tmo_next;
    end
  end

`ifdef PEAK_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (drop_next && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (err_next && err_cnt != 16'hFFFF)   err_cnt  <= err_cnt + 16'd1;
      if (tmo_next && tmo_cnt != 16'hFFFF)   tmo_cnt  <= tmo_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/peak_sched.md
# peak_sched

Frame scheduler placed between the FFT output stream and the `peak_detect` sink. `peak_detect` treats any `sink_eop` as a full reset, including while its output pipeline is still draining. This block therefore forwards a whole FFT frame only when the detector is idle and the decimation slot is due. While the detector runs, it holds back or drops frames, watches the detector's source stream for completion, and recovers from a stalled detector with a timeout.

## Interface
Parameters:
- `WIDTH`, 16: magnitude bus width, matching `peak_detect`.
- `NBINS`, 4096: expected beats per FFT frame, sop to eop inclusive.
- `NPEAKS`, 4: number of peak records expected from the detector per frame.
- `DECIM`, 1: forward one frame out of every `DECIM` frames, ≥1.
- `TIMEOUT`, 1024: cycles to wait in WAIT for detector completion.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `fft_valid`, `fft_sop`, `fft_eop`  in  1 each  FFT output stream framing.
- `fft_mag`  in  WIDTH  magnitude, UQ<WIDTH>.0.
- `fft_phase`  in  16  phase, Q1.15.
- `pd_sink_valid`, `pd_sink_sop`, `pd_sink_eop`  out  1 each  gated framing to the detector.
- `pd_sink_mag`  out  WIDTH  registered copy of `fft_mag`.
- `pd_sink_phase`  out  16  registered copy of `fft_phase`.
- `pd_valid`, `pd_eop`  in  1 each  monitor of the detector's `source_valid` and `source_eop`.
- `busy`  out  1  high in PASS or WAIT.
- `frame_done`  out  1  pulse: detector delivered its last record.
- `frame_drop`  out  1  pulse: a frame start was rejected.
- `frame_err`  out  1  pulse: framing or length error.
- `timeout`  out  1  pulse: detector did not finish within `TIMEOUT` cycles.

## Operation
- FSM states: IDLE, PASS, SKIP, WAIT. `dcnt` is the decimation counter, range 0..DECIM-1. `bcnt` is the bin counter, width `$clog2(NBINS)`, saturating.
- IDLE:
  - On `fft_valid && fft_sop`: if `dcnt==0`, forward the beat and go to PASS with `bcnt=0`; otherwise go to SKIP.
  - In both cases `dcnt` advances modulo DECIM.
  - A sop+eop beat in IDLE is forwarded, if due, and goes straight to WAIT.
- PASS:
  - Every valid beat is forwarded and `bcnt` increments.
  - On an eop beat: forward it and go to WAIT. If `bcnt != NBINS-1`, pulse `frame_err`.
  - On a sop beat without eop (new frame before eop): forward it as valid=1, sop=0, eop=1 to abort the detector, pulse `frame_err` and `frame_drop`, go to IDLE. `dcnt` is unchanged.
- SKIP:
  - Nothing is forwarded. The eop beat returns the FSM to IDLE.
  - A sop beat is handled exactly as in IDLE (resynchronisation).
- WAIT:
  - Nothing is forwarded. The timeout counter `tcnt` counts from 0 on entry.
  - Every sop beat seen pulses `frame_drop`. The rest of that frame is ignored implicitly, because IDLE waits for the next sop.
  - `pd_valid && pd_eop` pulses `frame_done` and goes to IDLE.
  - When `tcnt==TIMEOUT-1` with no completion, pulse `timeout` and go to IDLE.
  - If completion and timeout coincide, completion wins: `frame_done` pulses, `timeout` does not.
- Non-forwarded cycles drive `pd_sink_valid/sop/eop` to 0. Mag and phase are registered every cycle regardless of state.
- Reset mid-operation returns the FSM to IDLE with `dcnt=bcnt=tcnt=0`. The detector shares `reset`, so no abort beat is sent.

## Timing
- Forwarded framing and data appear exactly 1 cycle after the input beat.
- Status pulses (`frame_done`, `frame_drop`, `frame_err`, `timeout`) are registered. Each is high for one cycle, in the cycle after the causing event.
- `busy` is registered and reflects the state entered in the same edge.
- Reset values: all outputs 0, including `pd_sink_mag` and `pd_sink_phase`.
- Minimum frame period for 100% forwarding is `NBINS + T_detector` cycles. Faster frames are dropped, never queued.

## Configuration
- `PEAK_SCHED_STATS_EN`:
  - Defined: adds outputs `drop_cnt`, `err_cnt` and `tmo_cnt`, each 16 bits. They count pulses of `frame_drop`, `frame_err` and `timeout`, saturate at 0xFFFF, and are cleared by `reset`.
  - Undefined: these ports and their counters are absent. All other behaviour is identical.

## Test plan
Bench parameters: NBINS=16, DECIM=2, TIMEOUT=8.
- Frames 0 and 1 of 16 beats each, then detector `pd_eop` pulsed 3 cycles after frame 0's eop:
  - Frame 0 is forwarded with 1-cycle latency and correct sop/eop.
  - Frame 1 is not forwarded (decimation skip).
  - `frame_done` pulses once.
- Frame 2 starts while in WAIT → `frame_drop`=1 for one cycle, no forwarded beats, `busy` stays 1.
- No `pd_eop` after a forwarded frame → `timeout` pulses 8 cycles after entering WAIT, then IDLE and `busy`=0.
- New sop at beat 5 of a forwarded frame → forwarded beat carries eop=1, sop=0; `frame_err` and `frame_drop` pulse; FSM goes to IDLE.
- 12-beat frame with eop at beat 11 → forwarded, `frame_err` pulses, then WAIT.
- `pd_eop` in the same cycle as `tcnt`=7 → `frame_done`=1, `timeout`=0. With `PEAK_SCHED_STATS_EN` defined, `tmo_cnt` is unchanged.
